// File: rtl/lif_array.sv
// Array of N leaky integrate-and-fire neurons with shared threshold.
// Define LIF_REFRACTORY_EN to add per-channel refractory counters.
module lif_array #(
    parameter int N          = 4,
    parameter int WIDTH      = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int THR_RST    = 32,
    parameter int REFRAC     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] current,
    input  logic               in_valid,
    input  logic               thr_wr,
    input  logic [WIDTH-1:0]   thr_data,
    output logic [N*WIDTH-1:0] state_out,
    output logic [N-1:0]       spike,
    output logic [15:0]        spike_cnt
);

    logic [WIDTH-1:0] thr;
    logic [N-1:0]     refr;
    logic [N-1:0]     fire;
    logic [WIDTH-1:0] nxt [N];
    logic [4:0]       nfire;
    logic [16:0]      cnt_sum;

`ifdef LIF_REFRACTORY_EN
    logic [3:0] rcnt [N];

    // A channel is refractory while its counter is non-zero
    always_comb begin
        refr = '0;
        for (int i = 0; i < N; i++) begin
            refr[i] = (rcnt[i] != 4'd0);
        end
    end

    // Load on fire, count down on each update while refractory
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                rcnt[i] <= 4'd0;
            end
        end else if (in_valid) begin
            for (int i = 0; i < N; i++) begin
                if (refr[i]) begin
                    rcnt[i] <= rcnt[i] - 4'd1;
                end else if (fire[i]) begin
                    rcnt[i] <= 4'(REFRAC);
                end
            end
        end
    end
`else
    assign refr = '0;
`endif

    // Leak, integrate with saturation, compare against held threshold
    always_comb begin
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] sat;
        s       = '0;
        sat     = '0;
        fire    = '0;
        nfire   = '0;
        for (int i = 0; i < N; i++) begin
            s = {1'b0, current[i*WIDTH +: WIDTH]}
              + {1'b0, state_out[i*WIDTH +: WIDTH] >> LEAK_SHIFT};
            sat     = s[WIDTH] ? '1 : s[WIDTH-1:0];
            fire[i] = !refr[i] && (sat >= thr);
            nxt[i]  = (fire[i] || refr[i]) ? '0 : sat;
            nfire   = nfire + 5'(fire[i]);
        end
        cnt_sum = {1'b0, spike_cnt} + 17'(nfire);
    end

    // Register membrane state, spike flags, threshold and spike total
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_out <= '0;
            spike     <= '0;
            spike_cnt <= '0;
            thr       <= WIDTH'(THR_RST);
        end else begin
            if (thr_wr) begin
                thr <= thr_data;
            end
            spike <= in_valid ? fire : '0;
            if (in_valid) begin
                for (int i = 0; i < N; i++) begin
                    state_out[i*WIDTH +: WIDTH] <= nxt[i];
                end
                spike_cnt <= cnt_sum[16] ? 16'hffff : cnt_sum[15:0];
            end
        end
    end

endmodule

// File: tb/tb_lif_array.sv
// Directed self-checking bench for lif_array (N=4, WIDTH=8).
// Expected values are hand-computed; refractory cases follow LIF_REFRACTORY_EN.
module tb_lif_array;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] current = '0;
    logic        in_valid = 1'b0;
    logic        thr_wr = 1'b0;
    logic [7:0]  thr_data = '0;
    logic [31:0] state_out;
    logic [3:0]  spike;
    logic [15:0] spike_cnt;

    int checks = 0;
    int errors = 0;

    lif_array #(
        .N(4), .WIDTH(8), .LEAK_SHIFT(1), .THR_RST(32), .REFRAC(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .current(current),
        .in_valid(in_valid), .thr_wr(thr_wr), .thr_data(thr_data),
        .state_out(state_out), .spike(spike), .spike_cnt(spike_cnt)
    );

    always #5 clk = ~clk;

    task automatic upd(input logic [31:0] cur);
        current = cur;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        current = '0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic wthr(input logic [7:0] v);
        thr_wr = 1'b1;
        thr_data = v;
        @(posedge clk);
        #1;
        thr_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        checks++;
        if (state_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", state_out);
        end
        checks++;
        if (spike !== 4'h0) begin
            errors++;
            $display("FAIL reset_spike: got %h expected 0", spike);
        end
        checks++;
        if (spike_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", spike_cnt);
        end
    endtask

    task automatic test_fire();
        do_reset();
        upd(32'd20);
        checks++;
        if (state_out[7:0] !== 8'd20) begin
            errors++;
            $display("FAIL fire_s1: got %0d expected 20", state_out[7:0]);
        end
        upd(32'd20);
        checks++;
        if (state_out[7:0] !== 8'd30) begin
            errors++;
            $display("FAIL fire_s2: got %0d expected 30", state_out[7:0]);
        end
        idle();
        checks++;
        if (state_out[7:0] !== 8'd30 || spike !== 4'h0) begin
            errors++;
            $display("FAIL fire_hold: got %0d/%h expected 30/0",
                     state_out[7:0], spike);
        end
        upd(32'd20);
        checks++;
        if (state_out[7:0] !== 8'd0 || spike !== 4'b0001 || spike_cnt !== 16'd1) begin
            errors++;
            $display("FAIL fire_s3: got %0d/%h/%0d expected 0/1/1",
                     state_out[7:0], spike, spike_cnt);
        end
        idle();
        checks++;
        if (spike !== 4'h0 || spike_cnt !== 16'd1) begin
            errors++;
            $display("FAIL fire_pulse: got %h/%0d expected 0/1", spike, spike_cnt);
        end
    endtask

    task automatic test_leak();
        logic [7:0] tbl [5];
        logic [7:0] exp;
        tbl = '{8'd10, 8'd15, 8'd17, 8'd18, 8'd19};
        do_reset();
        for (int k = 0; k < 20; k++) begin
            upd(32'd10 << 8);
            exp = (k < 5) ? tbl[k] : 8'd19;
            checks++;
            if (state_out[15:8] !== exp || spike[1] !== 1'b0) begin
                errors++;
                $display("FAIL leak_%0d: got %0d/%b expected %0d/0",
                         k, state_out[15:8], spike[1], exp);
            end
        end
    endtask

    task automatic test_thr_sat();
        do_reset();
        wthr(8'd255);
        upd(32'd200 << 16);
        checks++;
        if (state_out[23:16] !== 8'd200 || spike !== 4'h0) begin
            errors++;
            $display("FAIL sat_s1: got %0d/%h expected 200/0",
                     state_out[23:16], spike);
        end
        upd(32'd200 << 16);
        checks++;
        if (state_out[23:16] !== 8'd0 || spike !== 4'b0100) begin
            errors++;
            $display("FAIL sat_fire: got %0d/%h expected 0/4",
                     state_out[23:16], spike);
        end
        thr_wr = 1'b1;
        thr_data = 8'd32;
        upd(32'd40);
        thr_wr = 1'b0;
        checks++;
        if (state_out[7:0] !== 8'd40 || spike !== 4'h0) begin
            errors++;
            $display("FAIL thr_old: got %0d/%h expected 40/0",
                     state_out[7:0], spike);
        end
        upd(32'd20);
        checks++;
        if (state_out[7:0] !== 8'd0 || spike !== 4'b0001) begin
            errors++;
            $display("FAIL thr_new: got %0d/%h expected 0/1",
                     state_out[7:0], spike);
        end
    endtask

    task automatic test_all_fire();
        do_reset();
        wthr(8'd0);
        upd(32'd0);
        checks++;
        if (spike !== 4'hf || spike_cnt !== 16'd4 || state_out !== 32'h0) begin
            errors++;
            $display("FAIL all_fire1: got %h/%0d expected f/4", spike, spike_cnt);
        end
        upd(32'd0);
`ifdef LIF_REFRACTORY_EN
        checks++;
        if (spike !== 4'h0 || spike_cnt !== 16'd4) begin
            errors++;
            $display("FAIL all_fire2: got %h/%0d expected 0/4", spike, spike_cnt);
        end
`else
        checks++;
        if (spike !== 4'hf || spike_cnt !== 16'd8) begin
            errors++;
            $display("FAIL all_fire2: got %h/%0d expected f/8", spike, spike_cnt);
        end
`endif
    endtask

    task automatic test_refrac();
        logic [7:0] es [3];
        logic [3:0] ek [3];
`ifdef LIF_REFRACTORY_EN
        es = '{8'd0, 8'd0, 8'd20};
        ek = '{4'h0, 4'h0, 4'h0};
`else
        es = '{8'd20, 8'd30, 8'd0};
        ek = '{4'h0, 4'h0, 4'h1};
`endif
        do_reset();
        upd(32'd20);
        upd(32'd20);
        upd(32'd20);
        for (int k = 0; k < 3; k++) begin
            upd(32'd20);
            checks++;
            if (state_out[7:0] !== es[k] || spike !== ek[k]) begin
                errors++;
                $display("FAIL refrac_%0d: got %0d/%h expected %0d/%h",
                         k, state_out[7:0], spike, es[k], ek[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wthr(8'd0);
        upd(32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state_out !== 32'h0 || spike !== 4'h0 || spike_cnt !== 16'h0) begin
            errors++;
            $display("FAIL rst_async: got %h/%h/%0d expected 0/0/0",
                     state_out, spike, spike_cnt);
        end
        current = 32'd20;
        in_valid = 1'b1;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        current = '0;
        checks++;
        if (state_out[7:0] !== 8'd20 || spike !== 4'h0) begin
            errors++;
            $display("FAIL rst_release: got %0d/%h expected 20/0",
                     state_out[7:0], spike);
        end
        upd(32'd20);
        upd(32'd20);
        checks++;
        if (state_out[7:0] !== 8'd0 || spike !== 4'b0001 || spike_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rst_thr: got %0d/%h/%0d expected 0/1/1",
                     state_out[7:0], spike, spike_cnt);
        end
    endtask

    task automatic test_cnt_sat();
        do_reset();
        wthr(8'd0);
        for (int k = 0; k < 49500; k++) begin
            upd(32'd0);
        end
        checks++;
        if (spike_cnt !== 16'hffff) begin
            errors++;
            $display("FAIL cnt_sat: got %0d expected 65535", spike_cnt);
        end
        upd(32'd0);
        checks++;
        if (spike_cnt !== 16'hffff || spike !== 4'hf) begin
            errors++;
            $display("FAIL cnt_hold: got %0d/%h expected 65535/f",
                     spike_cnt, spike);
        end
    endtask

    initial begin
        test_reset();
        test_fire();
        test_leak();
        test_thr_sat();
        test_all_fire();
        test_refrac();
        test_reset_mid();
        test_cnt_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lif_array.md
LIF_ARRAY -- requirements
Module: lif_array

Interface
REQ-001 Parameter N, default 4: number of independent neuron channels (1..16).
REQ-002 Parameter WIDTH, default 8: membrane-state and current width in bits (4..16).
REQ-003 Parameter LEAK_SHIFT, default 1: leak as right-shift of state per update (0..WIDTH-1).
REQ-004 Parameter THR_RST, default 32: threshold value after reset.
REQ-005 Parameter REFRAC, default 2: refractory length in update cycles (1..15).
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 current  input  N*WIDTH  per-channel input current; channel i at bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  1  update strobe; a cycle with in_valid=1 is one update cycle for all channels.
REQ-010 thr_wr  input  1  threshold load strobe.
REQ-011 thr_data  input  WIDTH  new threshold value, sampled when thr_wr=1.
REQ-012 state_out  output  N*WIDTH  registered membrane state per channel, same packing as current.
REQ-013 spike  output  N  registered per-channel spike flag.
REQ-014 spike_cnt  output  16  registered total spike count across all channels.

Function
REQ-015 Per channel, sum = current_i + (state_i >> LEAK_SHIFT), computed at WIDTH+1 bits and saturated to 2^WIDTH-1.
REQ-016 On an update cycle with channel not refractory: if sum >= threshold, state_i <= 0 and spike_i <= 1; else state_i <= sum and spike_i <= 0.
REQ-017 spike_i is high for exactly one clock after a firing update, independent of in_valid in the following cycle.
REQ-018 On a cycle with in_valid=0: state_i holds, spike_i <= 0, refractory counters hold.
REQ-019 Spike decision uses the threshold value held before the edge; thr_wr coincident with in_valid affects only subsequent updates.
REQ-020 Threshold 0: every non-refractory update fires.
REQ-021 spike_cnt increments by the number of channels firing in that update (0..N), saturating at 65535.
REQ-022 Latency: state_out and spike reflect an update one clock after the in_valid edge.

Reset
REQ-023 While rst_n=0, asynchronously: state_out=0, spike=0, spike_cnt=0, threshold=THR_RST, all refractory counters=0.
REQ-024 Reset asserted mid-operation (including during refractory) discards all state; first update after release behaves as from reset.
REQ-025 Release of rst_n is consumed on the next rising clk; an update strobe in that cycle is processed normally.

Configuration
REQ-026 Macro LIF_REFRACTORY_EN defined: a firing update loads the channel's refractory counter with REFRAC; each subsequent update cycle while counter > 0 decrements it, forces state_i to 0, ignores current_i, and sets spike_i <= 0.
REQ-027 Macro LIF_REFRACTORY_EN undefined: no refractory counters exist; every update follows REQ-016.

Verification (N=4, WIDTH=8, LEAK_SHIFT=1, THR_RST=32, REFRAC=2)
REQ-028 Assert rst_n=0 mid-stream, no clock -> state_out=0, spike=0, spike_cnt=0 immediately; threshold back to 32.
REQ-029 Channel 0 current=20 each update -> state 20, 30, then fire: state 0, spike[0]=1 one clock, spike_cnt=1.
REQ-030 Channel 1 current=10 each update for 20 updates -> state 10,15,17,18,19,19... never fires, spike[1]=0.
REQ-031 thr_wr with thr_data=255, then channel 2 current=200 twice -> sum 300 saturates to 255, fires; state 0, spike[2]=1.
REQ-032 LIF_REFRACTORY_EN defined, channel 0 current=20 after a fire -> next two updates state 0, no spike; third update state 20.
REQ-033 LIF_REFRACTORY_EN undefined, same stimulus -> update after fire gives state 20; all 4 channels firing together -> spike_cnt += 4.
